// File: rtl/mem_ctrl_v2_if.sv
// Request/response bundle for mem_ctrl_v2: valid/ready request in, read response out.
interface mem_ctrl_v2_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    init_done;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/mem_ctrl_v2.sv
// Single-port byte-lane memory with post-reset fill, byte-enable writes,
// range-checked accesses and a RD_LAT-deep read response pipeline.
module mem_ctrl_v2_lane #(
  parameter int DEPTH = 6,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module mem_ctrl_v2 #(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 6,
  parameter int                    RD_LAT     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input logic         clk,
  input logic         reset,
  mem_ctrl_v2_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]       LAST    = IW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;

  logic          run, acc, in_range, wr_go, rd_go;
  logic [IW-1:0] idx, mem_addr;
  logic [NB-1:0]       lane_we;
  logic [NB-1:0][7:0]  lane_wd, lane_rd;

  logic [RD_LAT:0]                 vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:0]                 err_pipe_q, err_pipe_d;
  logic [RD_LAT:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run      = (state_q == S_RUN);
  assign acc      = bus.req_valid & run;
  assign in_range = ({1'b0, bus.req_addr} < DEPTH_W);
  // Out-of-range requests still drive a legal index; their effects are masked below.
  assign idx      = in_range ? bus.req_addr[IW-1:0] : '0;
  assign mem_addr = run ? idx : cnt_q;
  assign wr_go    = acc & bus.req_wr & in_range;
  assign rd_go    = acc & ~bus.req_wr;
  assign lane_wd  = run ? bus.req_wdata : INIT_VALUE;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign lane_we[g] = ~run | (wr_go & bus.req_be[g]);
    mem_ctrl_v2_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane (
      .clk   (clk),
      .we    (lane_we[g]),
      .addr  (mem_addr),
      .wdata (lane_wd[g]),
      .rdata (lane_rd[g])
    );
  end

  // Stage 0 captures at acceptance; stage RD_LAT drives the response.
  // Data only moves with a valid token so rsp_rdata holds between pulses.
  always_comb begin
    vld_pipe_d    = '0;
    err_pipe_d    = '0;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[0] = rd_go;
    err_pipe_d[0] = rd_go & ~in_range;
    if (rd_go) dat_pipe_d[0] = in_range ? lane_rd : '0;
    for (int s = 1; s <= RD_LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      err_pipe_d[s] = err_pipe_q[s-1];
      if (vld_pipe_q[s-1]) dat_pipe_d[s] = dat_pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      err_pipe_q <= err_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign bus.req_ready = run;
  assign bus.init_done = run;
  assign bus.rsp_valid = vld_pipe_q[RD_LAT];
  assign bus.rsp_err   = err_pipe_q[RD_LAT];
  assign bus.rsp_rdata = dat_pipe_q[RD_LAT];
endmodule

// File: tb/tb_mem_ctrl_v2.sv
// Scoreboard bench: drives RD_LAT=1 and RD_LAT=2 instances with the same traffic.
module tb_mem_ctrl_v2;
  localparam int AW = 3, DW = 16, DEPTH = 6;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_v2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  mem_ctrl_v2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  mem_ctrl_v2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_ctrl_v2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(2))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {int due; logic [15:0] data; logic err;} exp_t;
  exp_t sb [2][$];

  int ecnt = 0;
  int errors = 0, checks = 0;
  int nvalid [2] = '{0, 0};
  logic [15:0] model [DEPTH];

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [15:0] d, input logic e);
    exp_t x;
    while (sb[id].size() > 0 && sb[id][0].due < ecnt) begin
      checks++; errors++;
      $display("FAIL rsp_missing dut%0d got=none exp=%h due=%0d", id + 1, sb[id][0].data, sb[id][0].due);
      void'(sb[id].pop_front());
    end
    if (v) begin
      nvalid[id]++;
      if (sb[id].size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected dut%0d got=%h exp=none cyc=%0d", id + 1, d, ecnt);
      end else begin
        x = sb[id].pop_front();
        chk($sformatf("rsp_time_dut%0d", id + 1), ecnt, x.due);
        chk($sformatf("rsp_data_dut%0d", id + 1), {16'h0, d}, {16'h0, x.data});
        chk($sformatf("rsp_err_dut%0d", id + 1), {31'h0, e}, {31'h0, x.err});
      end
    end else begin
      chk($sformatf("idle_err_dut%0d", id + 1), {31'h0, e}, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err);
    mon(1, bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err);
  end

  task automatic drive(input bit v, input bit wr, input logic [2:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    bus1.req_valid = v;  bus2.req_valid = v;
    bus1.req_wr    = wr; bus2.req_wr    = wr;
    bus1.req_addr  = a;  bus2.req_addr  = a;
    bus1.req_wdata = d;  bus2.req_wdata = d;
    bus1.req_be    = be; bus2.req_be    = be;
  endtask

  // Issued at a negedge, accepted at the following posedge (edge ecnt+1).
  task automatic op(input bit v, input bit wr, input logic [2:0] a,
                    input logic [15:0] d, input logic [1:0] be);
    exp_t x;
    @(negedge clk);
    drive(v, wr, a, d, be);
    if (v) chk("req_ready", {30'h0, bus1.req_ready, bus2.req_ready}, 32'h3);
    if (v && !wr) begin
      x.err  = (int'(a) >= DEPTH);
      x.data = x.err ? 16'h0 : model[a];
      x.due  = ecnt + 2; sb[0].push_back(x);
      x.due  = ecnt + 3; sb[1].push_back(x);
    end
    if (v && wr && int'(a) < DEPTH)
      for (int b = 0; b < 2; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic drain();
    int k = 0;
    op(0, 0, 3'd0, 16'h0, 2'b00);
    while ((sb[0].size() + sb[1].size()) > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain_outstanding", sb[0].size() + sb[1].size(), 32'h0);
  endtask

  // Reset is held low on entry; releases it and checks the DEPTH-cycle fill window.
  task automatic release_and_init();
    for (int i = 0; i < DEPTH; i++) model[i] = 16'hFFFF;
    @(negedge clk);
    chk("reset_state", {bus1.req_ready, bus1.init_done, bus1.rsp_valid, bus1.rsp_err,
                        bus2.req_ready, bus2.init_done, bus2.rsp_valid, bus2.rsp_err},
        32'h0);
    chk("reset_rdata", {bus1.rsp_rdata, bus2.rsp_rdata}, 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      chk($sformatf("init_window_%0d", k),
          {bus1.req_ready, bus1.init_done, bus2.req_ready, bus2.init_done},
          (k == DEPTH) ? 32'hF : 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ra;
    logic [15:0] rd;
    logic [1:0]  rb;
    bit          rv, rw;
    int          vsnap;

    drive(0, 0, 3'd0, 16'h0, 2'b00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    release_and_init();

    // Post-init contents
    for (int i = 0; i < DEPTH; i++) op(1, 0, 3'(i), 16'h0, 2'b00);
    drain();

    // Write then immediate read
    op(1, 1, 3'd2, 16'hA55A, 2'b11);
    op(1, 0, 3'd2, 16'h0, 2'b00);
    // Partial byte enables
    op(1, 1, 3'd3, 16'h1234, 2'b01);
    op(1, 0, 3'd3, 16'h0, 2'b00);
    op(1, 1, 3'd3, 16'hBEEF, 2'b00);
    op(1, 0, 3'd3, 16'h0, 2'b00);
    op(1, 1, 3'd5, 16'hC3D4, 2'b10);
    op(1, 0, 3'd5, 16'h0, 2'b00);
    drain();
    chk("model_addr3", {16'h0, model[3]}, 32'hFF34);

    // Out-of-range reads and dropped write
    op(1, 0, 3'd6, 16'h0, 2'b00);
    op(1, 0, 3'd7, 16'h0, 2'b00);
    op(1, 1, 3'd7, 16'h5555, 2'b11);
    op(1, 1, 3'd6, 16'h6666, 2'b11);
    for (int i = 0; i < DEPTH; i++) op(1, 0, 3'(i), 16'h0, 2'b00);
    drain();

    // Back-to-back reads (pipelined, both latencies)
    op(1, 0, 3'd0, 16'h0, 2'b00);
    op(1, 0, 3'd1, 16'h0, 2'b00);
    op(1, 0, 3'd2, 16'h0, 2'b00);
    drain();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rw = 1'($urandom_range(0, 1));
      ra = 3'($urandom_range(0, 7));
      rd = 16'($urandom);
      rb = 2'($urandom_range(0, 3));
      op(rv, rw, ra, rd, rb);
    end
    drain();

    // Reset with a read in flight: response discarded, contents refilled
    op(1, 1, 3'd2, 16'h0102, 2'b11);
    op(1, 0, 3'd2, 16'h0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 3'd0, 16'h0, 2'b00);
    sb[0].delete();
    sb[1].delete();
    vsnap = nvalid[0] + nvalid[1];
    repeat (2) @(negedge clk);
    release_and_init();
    chk("no_rsp_across_reset", nvalid[0] + nvalid[1], vsnap);
    op(1, 0, 3'd2, 16'h0, 2'b00);
    op(1, 0, 3'd0, 16'h0, 2'b00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_v2.md
Name: mem_ctrl_v2

Overview:
Parametrised single-port on-chip memory with a valid/ready request interface, byte-enable writes, selectable read latency and non-power-of-two depth. After reset it fills every word with INIT_VALUE using a counter-driven init sequence, one word per cycle. It replaces the fixed 4x8 scratch memory wherever a block needs a deeper or wider local store with a defined post-reset state and in-band error signalling.

Parameters:
ADDR_WIDTH, 3, request address width; must satisfy 2**ADDR_WIDTH >= DEPTH
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
DEPTH, 6, number of words; 1..2**ADDR_WIDTH, need not be a power of two
RD_LAT, 1, read latency in cycles; legal values 1 or 2
INIT_VALUE, all ones (DATA_WIDTH'hFF..F), value written to every word by init

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_wr  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  write data
req_be  input  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
rsp_valid  output  1  read response valid, single-cycle pulse per read
rsp_rdata  output  DATA_WIDTH  read data
rsp_err  output  1  qualifies rsp_valid; 1 = address out of range
init_done  output  1  high once init has completed

Behaviour:
- Reset (reset=0, asynchronous): state=INIT, init counter=0. req_ready, rsp_valid, rsp_err and init_done all 0. rsp_rdata=0. Read pipeline cleared.
- FSM has two states, INIT and RUN.
- INIT: each cycle writes INIT_VALUE to mem[cnt] with all bytes enabled, then increments cnt. When cnt==DEPTH-1 is written, the next state is RUN. INIT therefore lasts exactly DEPTH cycles after reset deasserts.
- During INIT: req_ready=0 and requests are ignored.
- RUN: init_done=1 and req_ready=1 on every cycle; the block never back-pressures. The FSM stays in RUN until reset.
- Request accepted when req_valid && req_ready.
- Accepted write with req_addr<DEPTH: for each i with req_be[i]=1, mem[addr] byte i <= req_wdata byte i. Disabled bytes keep their value. req_be=0 gives no change.
- Writes produce no response.
- Accepted write with req_addr>=DEPTH: dropped, memory unchanged, no response.
- Accepted read with req_addr<DEPTH: after exactly RD_LAT cycles, rsp_valid=1, rsp_rdata=mem[addr], rsp_err=0.
- Read timing: if accepted at edge N, the response is visible after edge N+RD_LAT. RD_LAT=2 adds one output register stage.
- Accepted read with req_addr>=DEPTH: same latency, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Reads are fully pipelined: back-to-back reads give back-to-back rsp_valid pulses in order.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- rsp_valid=0 whenever no response is due. rsp_rdata holds its last value and rsp_err=0 while rsp_valid=0.
- Reset asserted mid-operation: in-flight reads are discarded and no rsp_valid is produced for them. On release, INIT reruns and overwrites all prior contents.

Test Plan:
1. Release reset -> req_ready=0 and init_done=0 for 6 cycles, then both 1. Read addrs 0..5 -> 6 responses, each rdata=16'hFFFF and err=0.
2. RUN, RD_LAT=1: write addr 2 data 16'hA55A be=2'b11, then read addr 2 next cycle -> rsp_valid exactly 1 cycle after read acceptance, rdata=16'hA55A.
3. Write addr 3 data 16'h1234 be=2'b01 over 16'hFFFF -> read returns 16'hFF34. Write be=2'b00 -> still 16'hFF34.
4. Read addr 6 and addr 7 (>=DEPTH) -> rsp_valid with rsp_err=1 and rdata=0. Write addr 7 then read addrs 0..5 -> all unchanged.
5. RD_LAT=2: reads addr 0,1,2 on consecutive cycles -> three consecutive rsp_valid pulses starting 2 cycles after the first acceptance, data in order.
6. Issue read addr 2, assert reset on the next cycle -> no rsp_valid. After release, wait 6 cycles, read addr 2 -> 16'hFFFF.
